// File: rtl/wb_block_master_pkg.sv
// Shared types and constants for the Wishbone block-transfer initiator.
package wb_block_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StReq,
        StRdata,
        StDone,
        StErr
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wb_block_master.sv
// Wishbone classic-cycle initiator: moves a block of 32-bit words between a
// command/stream interface and a Wishbone slave, one bus cycle per word.
module wb_block_master
    import wb_block_master_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,

    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,

    output logic             busy,
    output logic             done,
    output logic             err,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    localparam int unsigned      TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e           r_state;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_rem;
    logic [TMO_W-1:0] r_tmo;
    logic [31:0]      r_wdat;
    logic [31:0]      r_rdat;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_wd_ready;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_err;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [3:0]       r_sel;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= StIdle;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_tmo       <= '0;
            r_wdat      <= '0;
            r_rdat      <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_wd_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr & ~32'd3;
                        r_rem       <= cmd_len;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if (cmd_write) begin
                            r_state    <= StWdata;
                            r_wd_ready <= 1'b1;
                        end else begin
                            r_state <= StReq;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_sel   <= WB_SEL_ALL;
                            r_tmo   <= '0;
                        end
                    end
                end

                StWdata: begin
                    if (wd_valid) begin
                        r_wdat     <= wd_data;
                        r_wd_ready <= 1'b0;
                        r_state    <= StReq;
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_we       <= 1'b1;
                        r_sel      <= WB_SEL_ALL;
                        r_tmo      <= '0;
                    end
                end

                StReq: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (wbm_ack_i) begin
                        r_cyc  <= 1'b0;
                        r_stb  <= 1'b0;
                        r_we   <= 1'b0;
                        r_sel  <= '0;
                        r_addr <= r_addr + WORD_BYTES;
                        r_rem  <= r_rem - LEN_W'(1);
                        if (!r_write) begin
                            r_rdat     <= wbm_dat_i;
                            r_rd_valid <= 1'b1;
                            r_state    <= StRdata;
                        end else if (r_rem == LEN_W'(1)) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= StWdata;
                            r_wd_ready <= 1'b1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                        r_state <= StErr;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                StRdata: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (r_rem == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StReq;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_sel   <= WB_SEL_ALL;
                            r_tmo   <= '0;
                        end
                    end
                end

                StDone: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end

                StErr: begin
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wd_ready  = r_wd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rdat;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_addr;
    assign wbm_dat_o = r_wdat;

endmodule

// File: tb/tb_wb_block_master.sv
// Randomized bench for wb_block_master: BRAM-like slave with fixed ack latency and
// a word-level memory model that predicts bus writes and read-back data.
module tb_wb_block_master;

    localparam int unsigned LAT     = 11;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned LEN_W   = 8;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wd_valid;
    logic             wd_ready;
    logic [31:0]      wd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [3:0]       sel;
    logic [31:0]      adr;
    logic [31:0]      dat_o;
    logic [31:0]      dat_i;
    logic             ack;
    logic             slv_ack;
    logic             spur_ack;

    assign ack = slv_ack | spur_ack;

    wb_block_master #(
        .LEN_W  (LEN_W),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wd_data  (wd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Slave: ack becomes visible in the LAT-th cycle of a strobe, sampled at the next edge.
    bit [31:0]   slv_mem [bit [31:0]];
    bit [31:0]   ref_mem [bit [31:0]];
    bus_t        bus_log[$];
    int unsigned pulse_len[$];
    int unsigned cur_len   = 0;
    int unsigned proto_err = 0;
    logic        prev_stb  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        ack_en    = 1'b1;

    always @(negedge clk) begin
        if (cyc && stb) begin
            cur_len = cur_len + 1;
            if (sel != 4'hF) proto_err++;
            if (prev_stb && prev_ack) proto_err++;
            if (rd_valid) proto_err++;
            if (!slv_ack && ack_en && cur_len == LAT) begin
                slv_ack = 1'b1;
                if (we) slv_mem[adr] = dat_o;
                else dat_i = slv_mem.exists(adr) ? slv_mem[adr] : 32'h0;
                bus_log.push_back({adr, we, we ? dat_o : dat_i});
            end
        end else begin
            if (cur_len != 0) pulse_len.push_back(cur_len);
            cur_len = 0;
            slv_ack = 1'b0;
            if (cyc || stb || sel != 4'h0) proto_err++;
        end
        prev_stb = cyc && stb;
        prev_ack = slv_ack;
    end

    logic [31:0] fixed_wd[$];

    task automatic run_block(input logic wr, input logic [31:0] addr, input int unsigned len,
                             input bit expect_err, input int unsigned ready_pct,
                             input int unsigned rd_hold, output int first_done);
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] wq[$];
        logic [31:0] exp_rd[$];
        bus_t        exp_bus[$];
        int unsigned n_done, n_err, n_rd, hold_left, budget, n_acks;
        int          tail;
        bit          stall;
        logic [31:0] hold_val;

        base = addr & ~32'h3;
        n_done = 0; n_err = 0; n_rd = 0; hold_left = rd_hold; tail = -1;
        stall = 1'b0; hold_val = '0; first_done = -1;
        budget = 100 + len * 60 + rd_hold;
        bus_log.delete();
        pulse_len.delete();
        proto_err = 0;

        for (int i = 0; i < int'(len); i++) begin
            a = base + 32'(4 * i);
            if (wr) begin
                d = (i < fixed_wd.size()) ? fixed_wd[i] : $urandom;
                wq.push_back(d);
                if (!expect_err) begin
                    ref_mem[a] = d;
                    exp_bus.push_back({a, 1'b1, d});
                end
            end else begin
                d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                exp_rd.push_back(d);
                if (!expect_err) exp_bus.push_back({a, 1'b0, d});
            end
        end
        fixed_wd.delete();

        @(negedge clk);
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);

        for (int c = 0; c < int'(budget); c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (c == 0) check_eq("busy_after_cmd", {busy, cmd_ready}, 2'b10);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (err) n_err++;
            if (stall) check_eq("rd_hold_stable", {rd_valid, rd_data}, {1'b1, hold_val});
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end else if (tail < 0 && (n_done + n_err) > 0) begin
                tail = 3;
            end

            if (rd_valid && hold_left > 0) begin
                rd_ready = 1'b0;
                hold_left--;
            end else begin
                rd_ready = ($urandom_range(99) < ready_pct);
            end
            if (rd_valid && rd_ready) begin
                n_rd++;
                if (exp_rd.size() > 0) check_eq("rd_data", rd_data, exp_rd.pop_front());
                else check_eq("rd_extra_word", 1, 0);
            end
            stall    = rd_valid && !rd_ready;
            hold_val = rd_data;

            wd_valid = (wq.size() > 0) && ($urandom_range(99) < ready_pct);
            wd_data  = wd_valid ? wq[0] : $urandom;
            if (wd_valid && wd_ready) void'(wq.pop_front());
        end
        rd_ready = 1'b0;
        wd_valid = 1'b0;

        check_eq("done_pulses", n_done, expect_err ? 0 : 1);
        check_eq("err_pulses", n_err, expect_err ? 1 : 0);
        if (!expect_err) check_eq("rd_words", n_rd, wr ? 0 : len);
        check_eq("bus_count", bus_log.size(), exp_bus.size());
        n_acks = (bus_log.size() < exp_bus.size()) ? bus_log.size() : exp_bus.size();
        for (int i = 0; i < int'(n_acks); i++) begin
            check_eq("bus_adr", bus_log[i].adr, exp_bus[i].adr);
            check_eq("bus_we_dat", {bus_log[i].we, bus_log[i].dat},
                     {exp_bus[i].we, exp_bus[i].dat});
        end
        check_eq("pulse_count", pulse_len.size(), expect_err ? 1 : len);
        foreach (pulse_len[i])
            check_eq("stb_high_cycles", pulse_len[i], expect_err ? TIMEOUT : LAT);
        check_eq("protocol_errors", proto_err, 0);
        check_eq("cmd_ready_after", {cmd_ready, busy}, 2'b10);
    endtask

    int          fd;
    int unsigned rlen;
    logic [31:0] raddr;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0; dat_i = '0;
        slv_ack = 1'b0; spur_ack = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready_busy", {cmd_ready, busy, done, err}, 4'b1000);
        check_eq("rst_streams", {wd_ready, rd_valid, rd_data}, 34'h0);
        check_eq("rst_wb_ctl", {cyc, stb, we, sel}, 7'h0);
        check_eq("rst_wb_adr_dat", {adr, dat_o}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed write then read-back against the BRAM-like slave.
        fixed_wd = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_block(1'b1, 32'h3800_0000, 4, 1'b0, 100, 0, fd);
        run_block(1'b0, 32'h3800_0000, 4, 1'b0, 100, 0, fd);

        // Backpressure on the read stream.
        run_block(1'b0, 32'h3800_0000, 2, 1'b0, 100, 20, fd);

        // Timeout: slave never acks.
        ack_en = 1'b0;
        run_block(1'b0, 32'h3800_0000, 3, 1'b1, 100, 0, fd);
        ack_en = 1'b1;

        // Zero length, then address wrap.
        run_block(1'b0, 32'h1234_5678, 0, 1'b0, 100, 0, fd);
        check_eq("zero_len_done_cycle", fd, 0);
        run_block(1'b1, 32'hFFFF_FFFC, 2, 1'b0, 70, 0, fd);
        run_block(1'b0, 32'hFFFF_FFFE, 2, 1'b0, 70, 0, fd);

        // Ack while idle must be ignored.
        @(negedge clk);
        spur_ack = 1'b1;
        repeat (2) @(negedge clk);
        spur_ack = 1'b0;
        check_eq("spurious_ack_idle", {cmd_ready, busy, cyc, done, err}, 5'b10000);

        // Reset during the second word's bus cycle.
        bus_log.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3800_0000; cmd_len = LEN_W'(3);
        @(negedge clk);
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (bus_log.size() == 1 && cyc && stb) break;
            @(negedge clk);
        end
        check_eq("mid_reset_in_word2", {bus_log.size() == 1, cyc, stb}, 3'b111);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_async_drop", {cyc, stb, busy, done, err, sel}, 9'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        fd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || err || cyc) fd++;
        end
        check_eq("after_reset_ready", {cmd_ready, busy}, 2'b10);
        check_eq("after_reset_no_pulse", fd, 0);

        // Random write/read-back pairs with random stream throttling.
        for (int k = 0; k < 8; k++) begin
            raddr = (k % 3 == 2) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            rlen  = $urandom_range(0, 5);
            run_block(1'b1, raddr, rlen, 1'b0, $urandom_range(40, 100), 0, fd);
            run_block(1'b0, raddr, rlen, 1'b0, $urandom_range(40, 100), $urandom_range(0, 4), fd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_block_master.md
Name: wb_block_master

Overview:
- Wishbone classic-cycle initiator that moves a block of 32-bit words between a simple command/stream interface and a Wishbone slave, e.g. the user-area BRAM wrapper, which acks after a fixed multi-cycle latency.
- Used by user logic (FIR engine, test harness) to fill or drain external memory without firmware involvement.
- One bus transaction per word; no pipelining or burst tags.

Parameters:
- LEN_W, 8, width of the word-count field (max block = 2^LEN_W-1 words)
- TIMEOUT, 32, cycles to wait for wbm_ack_i before aborting; must exceed slave latency (BRAM wrapper: 11)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write block, 0 = read block
- cmd_addr  in  32  byte base address, word aligned
- cmd_len  in  LEN_W  number of words
- wd_valid  in  1  write-data stream valid
- wd_ready  out  1  write-data accepted
- wd_data  in  32  write-data word
- rd_valid  out  1  read-data stream valid
- rd_ready  in  1  downstream accepts read word
- rd_data  out  32  read-data word
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, block completed
- err  out  1  one-cycle pulse, block aborted on timeout
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  byte selects, always 4'hF during a cycle, 0 otherwise
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready=1. Address, count, timeout and data registers are cleared.
- All Wishbone outputs are registered.
- Handshake: a transfer occurs on a cycle where valid && ready at the rising edge.
- States:
  - IDLE: on cmd_valid, latch addr/len/write.
    - len==0: go to DONE with no bus activity.
    - write: go to WDATA.
    - read: go to REQ.
  - WDATA: wd_ready=1. On wd_valid, latch wd_data into wbm_dat_o and go to REQ.
  - REQ: cyc=stb=1, we=write, adr=current address, sel=4'hF; timeout counter increments each cycle.
    - ack sampled high: deassert cyc/stb at that same edge; capture wbm_dat_i if reading; decrement remaining count; address += 4.
      - Read: go to RDATA.
      - Write: go to DONE if remaining now 0, else WDATA.
    - Counter reaches TIMEOUT-1 with no ack: deassert cyc/stb and go to ERR.
  - RDATA: rd_valid=1, rd_data held stable until rd_ready. On rd_ready, go to DONE if remaining is 0, else REQ.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 for one cycle, then IDLE. Remaining words are discarded; no further bus cycles.
- Cycle spacing:
  - stb is low for at least one cycle between consecutive words.
  - Minimum write latency per word = 1 (WDATA) + slave latency + 1.
- Timeout counter clears on entry to REQ.
- Ack seen on the same cycle the counter hits TIMEOUT-1: ack wins, no error.
- Address wraps modulo 2^32. cmd_addr[1:0] are ignored and forced to 0 on wbm_adr_o.
- wbm_ack_i outside REQ is ignored.
- Reset asserted mid-transfer: cyc/stb drop asynchronously; no done/err pulse is issued.

Decomposition:
- Shared package: state enum (IDLE, WDATA, REQ, RDATA, DONE, ERR), WB_SEL_ALL=4'hF, WORD_BYTES=4.
- No sub-module is natural. The timeout counter is a small inline counter; the FSM plus datapath stay in one module.

Test Plan:
- Write block: cmd write, addr 0x3800_0000, len 4, wd_data 0x11,0x22,0x33,0x44 against the BRAM slave → four WB writes at 0x3800_0000/04/08/0C with sel=F, stb low between them, one done pulse, no err.
- Read-back: cmd read, same addr, len 4 → rd_data sequence 0x11,0x22,0x33,0x44, each ack 11 cycles after stb rise, done after the 4th rd handshake.
- Backpressure: read len 2 with rd_ready held low 20 cycles → rd_data stable, no second stb until the first word is consumed; done after the 2nd word.
- Timeout: slave never acks, TIMEOUT=32, read len 3 → cyc/stb high exactly 32 cycles, then low, err pulse once, no done, cmd_ready back to 1.
- Zero length and wrap: len 0 → done on the cycle after the command, no cyc. Then write len 2 at 0xFFFF_FFFC → addresses 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-operation: assert wb_rst_ni low during REQ of word 2 → cyc/stb/busy go 0 immediately, cmd_ready=1 after release, no done/err pulse.
